dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single synchronous-read data RAM between two requesters.
- m0 is the CPU MEM stage; m1 is a secondary master, such as the debug/program loader or the future IF refill path.
- Fixed priority goes to m0. A starvation guard guarantees m1 service.
- Reads return one cycle after grant. Requests may issue back-to-back, so the arbiter tracks the owner of the in-flight read.

Parameters:
- STARVE_LIMIT, 4: consecutive denied cycles of m1 before m1 gets priority. 0 means pure fixed priority for m0, with no guard.
- AW, 32: address width.
- DW, 32: data width; DW/8 byte enables.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  m0 request; held with addr/wen/wdata until m0_gnt.
- m0_addr  in  AW  m0 byte address.
- m0_wen  in  DW/8  m0 byte write enables; 0 means a read.
- m0_wdata  in  DW  m0 write data, already lane-aligned.
- m0_gnt  out  1  m0 request accepted this cycle (combinational).
- m0_rvalid  out  1  m0 read data valid (registered).
- m0_rdata  out  DW  m0 read data.
- m1_req, m1_addr, m1_wen, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the m0 ports, for m1.
- ram_addr  out  AW  RAM address.
- ram_wen  out  DW/8  RAM byte write enables.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data; valid in the cycle after the address is sampled.
- owner  out  1  master granted this cycle: 0 = m0, 1 = m1; holds its last value when idle.

Behaviour:
- Reset (synchronous, active-high):
  - gnts, rvalids, ram_wen and ram_addr are 0.
  - rd_pending=0, rd_owner=0, pri=M0, starve_cnt=0, owner=0.
- Priority FSM, states PRI_M0 and PRI_M1:
  - PRI_M0 -> PRI_M1 when m1_req & ~m1_gnt and starve_cnt==STARVE_LIMIT-1 (only if STARVE_LIMIT>0).
  - PRI_M1 -> PRI_M0 on the cycle m1_gnt=1.
- Starvation counter:
  - Increments while m1_req & ~m1_gnt, saturating at STARVE_LIMIT.
  - Clears on m1_gnt or when ~m1_req.
- Grant, combinational, at most one per cycle:
  - In PRI_M0: m0 wins if m0_req, otherwise m1 if m1_req.
  - In PRI_M1: m1 wins if m1_req, otherwise m0.
- Datapath:
  - ram_addr/ram_wen/ram_wdata are muxed from the winner in the same cycle.
  - With no grant, ram_wen=0 and ram_addr holds the winner mux default, which is m0_addr.
  - The RAM samples at the clock edge ending grant cycle T.
- Read completion:
  - A granted read (wen==0) sets rd_pending=1 and rd_owner=winner at the end of T.
  - In T+1, mX_rvalid=1 for rd_owner only, and mX_rdata=ram_rdata. The other master's rvalid=0.
  - Both rdata outputs carry ram_rdata; only rvalid qualifies them.
- Writes complete in the grant cycle; no rvalid is produced.
- Back-to-back: a new grant is allowed in T+1 while the T read returns. rd_pending/rd_owner are reloaded every cycle, which gives full throughput of one access per cycle.
- Simultaneous requests: exactly one gnt. The loser must hold its request; the arbiter does not queue.
- Dropped request: deasserting req before gnt drops the request, and starve_cnt clears.
- Reset in T+1 of a read: rvalid is forced 0 in that cycle and in all following cycles until a new read is granted.
- Address and byte-lane checks: none. The requester performs alignment and exception checks before asserting req.

Decomposition:
- Shared package dmem_pkg:
  - PRI_M0/PRI_M1 state encodings.
  - OWNER_M0/OWNER_M1 constants.
  - Default STARVE_LIMIT.
- Sub-module dmem_starve_ctr: saturating counter plus PRI FSM; outputs pri.
- The mux and return logic stay in the top module.

Test Plan:
- Single m0 read, m1 idle: m0_req=1, m0_addr=0x00000010, wen=0 in cycle 0.
  - Cycle 0: m0_gnt=1, ram_addr=0x10, ram_wen=0.
  - Cycle 1 (RAM holds 0xDEADBEEF): m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- Contention with a write:
  - Cycle 0: both req; m0 write 0x20, wen=4'b1111, wdata=0x12345678 -> m0_gnt=1, m1_gnt=0, ram_wen=4'b1111.
  - Cycle 1: m0 idle -> m1_gnt=1.
- Starvation guard with STARVE_LIMIT=4: m0_req and m1_req held high continuously.
  - m0 is granted in cycles 0-3 and m1 in cycle 4.
  - m0 wins cycles 5-8 and m1 wins cycle 9.
- Back-to-back reads:
  - m0 read 0x30 in cycle 0, then m1 read 0x34 in cycle 1.
  - Cycle 1: m0_rvalid=1 with data@0x30.
  - Cycle 2: m1_rvalid=1 with data@0x34; no rvalid overlap.
- Reset mid-read: read granted in cycle 0, reset=1 in cycle 1.
  - Cycle 1: m0_rvalid=0.
  - Cycle 2: all outputs at reset values; starve_cnt=0, pri=PRI_M0.
- Byte write from m1: m1 wen=4'b0100, wdata=0x00AB0000, addr 0x42, m0 idle.
  - m1_gnt=1, ram_wen=4'b0100, ram_wdata=0x00AB0000, ram_addr=0x42.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Priority state encodings, owner codes and the default starvation limit.
package dmem_pkg;

    typedef enum logic {
        PRI_M0 = 1'b0,
        PRI_M1 = 1'b1
    } pri_e;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Starvation guard for the secondary master.
// Counts consecutive denied m1 cycles and flips priority to m1 at the limit.
module dmem_starve_ctr
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic m1_req,
    input  logic m1_gnt,
    output pri_e pri
);

    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIM    = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] LIM_M1 = CW'((STARVE_LIMIT > 0) ? STARVE_LIMIT - 1 : 0);

    logic [CW-1:0] cnt;
    logic          denied;

    assign denied = m1_req & ~m1_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            pri <= PRI_M0;
        end else begin
            if (denied) begin
                if (cnt != LIM) cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            // A limit of zero disables the guard entirely
            unique case (pri)
                PRI_M0: if (STARVE_LIMIT > 0 && denied && cnt == LIM_M1) pri <= PRI_M1;
                PRI_M1: if (m1_gnt) pri <= PRI_M0;
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the synchronous-read data RAM.
// m0 has fixed priority; m1 is guaranteed service by the starvation guard.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_req,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW/8-1:0] m0_wen,
    input  logic [DW-1:0]   m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_req,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW/8-1:0] m1_wen,
    input  logic [DW-1:0]   m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,
    output logic [AW-1:0]   ram_addr,
    output logic [DW/8-1:0] ram_wen,
    output logic [DW-1:0]   ram_wdata,
    input  logic [DW-1:0]   ram_rdata,
    output logic            owner
);

    pri_e pri;
    logic win_m1;
    logic any_gnt;
    logic rd_pending;
    logic rd_owner;
    logic owner_q;

    dmem_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .m1_req(m1_req),
        .m1_gnt(m1_gnt),
        .pri   (pri)
    );

    assign win_m1  = (pri == PRI_M1) ? m1_req : (m1_req & ~m0_req);
    assign m1_gnt  = ~reset & win_m1;
    assign m0_gnt  = ~reset & m0_req & ~win_m1;
    assign any_gnt = m0_gnt | m1_gnt;

    always_comb begin
        ram_addr  = m1_gnt ? m1_addr : m0_addr;
        ram_wdata = m1_gnt ? m1_wdata : m0_wdata;
        ram_wen   = '0;
        if (m1_gnt)      ram_wen = m1_wen;
        else if (m0_gnt) ram_wen = m0_wen;
        if (reset) ram_addr = '0;
    end

    always_comb begin
        owner = owner_q;
        if (any_gnt) owner = m1_gnt ? OWNER_M1 : OWNER_M0;
        if (reset)   owner = OWNER_M0;
    end

    // Reloaded every cycle so a new access can issue while the last read returns
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pending <= 1'b0;
            rd_owner   <= OWNER_M0;
            owner_q    <= OWNER_M0;
        end else begin
            rd_pending <= any_gnt & (ram_wen == '0);
            rd_owner   <= m1_gnt ? OWNER_M1 : OWNER_M0;
            if (any_gnt) owner_q <= m1_gnt ? OWNER_M1 : OWNER_M0;
        end
    end

    assign m0_rvalid = ~reset & rd_pending & (rd_owner == OWNER_M0);
    assign m1_rvalid = ~reset & rd_pending & (rd_owner == OWNER_M1);
    assign m0_rdata  = ram_rdata;
    assign m1_rdata  = ram_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic.
// A reference model predicts grants and read data; a monitor scores returns.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wen, m1_wen;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_wen;
    logic        owner;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(LIM), .AW(32), .DW(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_wen   (m0_wen),
        .m0_wdata (m0_wdata),
        .m0_gnt   (m0_gnt),
        .m0_rvalid(m0_rvalid),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_wen   (m1_wen),
        .m1_wdata (m1_wdata),
        .m1_gnt   (m1_gnt),
        .m1_rvalid(m1_rvalid),
        .m1_rdata (m1_rdata),
        .ram_addr (ram_addr),
        .ram_wen  (ram_wen),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .owner    (owner)
    );

    // Environment RAM and the model's private copy of its contents
    logic [31:0] ram [64];
    logic [31:0] ref_mem [64];

    always @(posedge clk) begin
        ram_rdata <= ram[ram_addr[7:2]];
        for (int b = 0; b < 4; b++)
            if (ram_wen[b]) ram[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    typedef struct {
        int          due;
        logic        who;
        logic [31:0] data;
    } rd_t;

    rd_t q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    bit  owed;
    int  streak;
    logic last_owner;
    bit  g0_seen, g1_seen;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %h want %h", nm, cyc, act, exp);
        end
    endfunction

    // Reference model: m1 is "owed" a turn after LIM consecutive denials
    always @(negedge clk) begin
        bit          e0, e1;
        logic [31:0] a, d;
        logic [3:0]  w;
        g0_seen = m0_gnt;
        g1_seen = m1_gnt;
        if (reset) begin
            chk("rst_m0_gnt", 32'(m0_gnt), 0);
            chk("rst_m1_gnt", 32'(m1_gnt), 0);
            chk("rst_ram_wen", 32'(ram_wen), 0);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_owner", 32'(owner), 0);
            owed = 0;
            streak = 0;
            last_owner = 0;
        end else begin
            e1 = m1_req && (owed || !m0_req);
            e0 = m0_req && !e1;
            chk("m0_gnt", 32'(m0_gnt), 32'(e0));
            chk("m1_gnt", 32'(m1_gnt), 32'(e1));
            a = e1 ? m1_addr : m0_addr;
            d = e1 ? m1_wdata : m0_wdata;
            w = e1 ? m1_wen : m0_wen;
            if (e0 || e1) begin
                chk("ram_addr", ram_addr, a);
                chk("ram_wen", 32'(ram_wen), 32'(w));
                chk("ram_wdata", ram_wdata, d);
                if (w == 4'h0) begin
                    q.push_back('{cyc + 1, e1, ref_mem[a[7:2]]});
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (w[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
                end
                last_owner = e1;
            end else begin
                chk("idle_ram_wen", 32'(ram_wen), 0);
                chk("idle_ram_addr", ram_addr, m0_addr);
            end
            chk("owner", 32'(owner), 32'(last_owner));
            if (e1) begin
                owed = 0;
                streak = 0;
            end else if (m1_req) begin
                streak++;
                if (LIM > 0 && streak >= LIM) owed = 1;
            end else begin
                streak = 0;
            end
        end
    end

    // Monitor: scores every read return against the queued expectation
    always @(negedge clk) begin
        rd_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("rvalid_m0", 32'(m0_rvalid), 32'(!e.who));
            chk("rvalid_m1", 32'(m1_rvalid), 32'(e.who));
            chk("rdata", e.who ? m1_rdata : m0_rdata, e.data);
        end else begin
            chk("no_rvalid", 32'({m1_rvalid, m0_rvalid}), 0);
        end
    end

    task automatic set0(bit r, logic [31:0] a, logic [3:0] w, logic [31:0] d);
        m0_req = r; m0_addr = a; m0_wen = w; m0_wdata = d;
    endtask

    task automatic set1(bit r, logic [31:0] a, logic [3:0] w, logic [31:0] d);
        m1_req = r; m1_addr = a; m1_wen = w; m1_wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit p0, p1;
        for (int i = 0; i < 64; i++) begin
            ram[i] = 32'hA500_0000 + 32'(i) * 32'h0101_0101;
            ref_mem[i] = ram[i];
        end
        reset = 1;
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        tick();
        tick();
        reset = 0;

        // m0 write then read of 0xDEADBEEF
        set0(1, 32'h10, 4'hF, 32'hDEADBEEF); tick();
        set0(1, 32'h10, 4'h0, 0); tick();
        set0(0, 0, 0, 0); tick();

        // contention: m0 write wins, m1 read follows
        set0(1, 32'h20, 4'hF, 32'h12345678);
        set1(1, 32'h20, 4'h0, 0); tick();
        set0(0, 0, 0, 0); tick();
        set1(0, 0, 0, 0); tick();

        // both hold requests: guard must hand m1 cycles 4 and 9
        set0(1, 32'h30, 4'h0, 0);
        set1(1, 32'h34, 4'h0, 0);
        repeat (10) tick();
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0); tick();

        // back-to-back reads from different masters
        set0(1, 32'h30, 4'h0, 0); tick();
        set0(0, 0, 0, 0);
        set1(1, 32'h34, 4'h0, 0); tick();
        set1(0, 0, 0, 0); tick();

        // m1 byte write, then read back
        set1(1, 32'h42, 4'b0100, 32'h00AB0000); tick();
        set1(1, 32'h40, 4'h0, 0); tick();
        set1(0, 0, 0, 0); tick();

        // reset lands in the return cycle of a read
        set0(1, 32'h10, 4'h0, 0); tick();
        set0(0, 0, 0, 0);
        reset = 1;
        q.delete();
        tick();
        reset = 0; tick();
        tick();

        // random traffic with holds, drops and occasional resets
        p0 = 0;
        p1 = 0;
        for (int i = 0; i < 600; i++) begin
            if (p0 && g0_seen) p0 = 0;
            if (p1 && g1_seen) p1 = 0;
            if (p0 && $urandom_range(15) == 0) p0 = 0;
            if (p1 && $urandom_range(15) == 0) p1 = 0;
            if (!p0) m0_req = 0;
            if (!p1) m1_req = 0;
            if (!p0 && $urandom_range(3) != 0) begin
                p0 = 1;
                set0(1, {24'h0, 6'($urandom_range(63)), 2'b00},
                     $urandom_range(1) ? 4'h0 : 4'($urandom_range(15)), $urandom);
            end
            if (!p1 && $urandom_range(1) != 0) begin
                p1 = 1;
                set1(1, {24'h0, 6'($urandom_range(63)), 2'b00},
                     $urandom_range(1) ? 4'h0 : 4'($urandom_range(15)), $urandom);
            end
            if ($urandom_range(63) == 0) begin
                reset = 1;
                q.delete();
                p0 = 0;
                p1 = 0;
                m0_req = 0;
                m1_req = 0;
            end else begin
                reset = 0;
            end
            tick();
        end
        reset = 0;
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
